cbd_ctrl: RTL and testbench

Sequencer for the `cbd` sampler in the Kyber noise-sampling path. It drives one η=2 noise polynomial per `start`:
- clears `cbd`;
- streams PRF output word pairs from an upstream valid/ready source into the `cbd` input handshake;
- drains coefficient pairs from the `cbd` output handshake;
- reduces the coefficients into [0, Q) and writes them as packed pairs to the polynomial RAM.

It sits between the SHAKE/PRF word buffer and the polynomial memory and owns all `cbd` control pins.

---
 rtl/cbd_ctrl.sv | 154 +++++++++++++++
 tb/tb_cbd_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbd_ctrl.sv
// Sequencer for one eta=2 cbd noise polynomial: clears cbd, feeds PRF word pairs,
// drains coefficient pairs, lifts them into [0, Q) and writes packed pairs to RAM.
module cbd_ctrl #(
  parameter int Q         = 3329,
  parameter int IN_PAIRS  = 16,
  parameter int OUT_PAIRS = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [31:0]        src_data_1,
  input  logic [31:0]        src_data_2,
  output logic               cbd_set,
  output logic               cbd_reset,
  output logic               cbd_readin,
  output logic [31:0]        cbd_din_1,
  output logic [31:0]        cbd_din_2,
  input  logic               cbd_ok_in,
  output logic               cbd_readout,
  input  logic               cbd_ok_out,
  input  logic signed [15:0] cbd_dout_1,
  input  logic signed [15:0] cbd_dout_2,
  input  logic               poly_ready,
  output logic               poly_we,
  output logic [6:0]         poly_addr,
  output logic [23:0]        poly_wdata,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  in_cnt_q, in_cnt_d;
  logic [7:0]  out_cnt_q, out_cnt_d;
  logic        poly_we_q;
  logic [6:0]  poly_addr_q;
  logic [23:0] poly_wdata_q;
  logic        done_q;

  logic run_s, flush_s, xfer_s, cap_s, last_in_s, last_out_s;

  // Coefficients arrive in [-2, 2]; negative ones are lifted by Q before truncation.
  function automatic logic [11:0] to_mod_q(input logic signed [15:0] c);
    logic signed [15:0] r;
    if (c < 16'sd0) begin
      r = c + $signed(16'(Q));
    end else begin
      r = c;
    end
    return r[11:0];
  endfunction

  assign run_s   = (state_q == S_RUN);
  assign flush_s = (state_q == S_FLUSH);

  assign cbd_din_1   = src_data_1;
  assign cbd_din_2   = src_data_2;
  assign cbd_readin  = run_s && src_valid;
  assign src_ready   = run_s && cbd_ok_in;
  assign cbd_readout = (run_s || flush_s) && poly_ready;
  assign cbd_reset   = reset || (state_q == S_CLR);
  assign cbd_set     = (state_q == S_CLR) || run_s || flush_s;
  assign busy        = (state_q != S_IDLE);

  assign xfer_s     = run_s && src_valid && cbd_ok_in;
  assign cap_s      = cbd_readout && cbd_ok_out;
  assign last_in_s  = xfer_s && (in_cnt_q == 5'(IN_PAIRS - 1));
  assign last_out_s = cap_s && (out_cnt_q == 8'(OUT_PAIRS - 1));

  assign poly_we    = poly_we_q;
  assign poly_addr  = poly_addr_q;
  assign poly_wdata = poly_wdata_q;
  assign done       = done_q;

  // Next-state and counter update; an output completion wins over the input boundary.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (xfer_s) begin
      in_cnt_d = in_cnt_q + 5'd1;
    end else begin
      in_cnt_d = in_cnt_q;
    end
    if (cap_s) begin
      out_cnt_d = out_cnt_q + 8'd1;
    end else begin
      out_cnt_d = out_cnt_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLR;
          in_cnt_d  = 5'd0;
          out_cnt_d = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: state_d = S_RUN;
      S_RUN: begin
        if (last_out_s) begin
          state_d = S_DONE;
        end else if (last_in_s) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        if (last_out_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and the registered RAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      in_cnt_q     <= 5'd0;
      out_cnt_q    <= 8'd0;
      poly_we_q    <= 1'b0;
      poly_addr_q  <= 7'd0;
      poly_wdata_q <= 24'd0;
      done_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      poly_we_q <= cap_s;
      done_q    <= last_out_s;
      if (cap_s) begin
        poly_addr_q  <= out_cnt_q[6:0];
        poly_wdata_q <= {to_mod_q(cbd_dout_2), to_mod_q(cbd_dout_1)};
      end
    end
  end

endmodule

// File: tb/tb_cbd_ctrl.sv
// Bench for cbd_ctrl: behavioural cbd model, expected-write scoreboard and a
// coefficient-mapping vector table, plus reset, backpressure and abort sequences.
module tb_cbd_ctrl;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b1;
  logic               src_valid = 1'b1;
  logic               src_ready;
  logic [31:0]        src_data_1, src_data_2;
  logic               cbd_set, cbd_reset, cbd_readin, cbd_readout;
  logic [31:0]        cbd_din_1, cbd_din_2;
  logic               cbd_ok_in, cbd_ok_out;
  logic signed [15:0] cbd_dout_1, cbd_dout_2;
  logic               poly_ready = 1'b1;
  logic               poly_we;
  logic [6:0]         poly_addr;
  logic [23:0]        poly_wdata;
  logic               busy, done;

  cbd_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_data_1(src_data_1), .src_data_2(src_data_2),
    .cbd_set(cbd_set), .cbd_reset(cbd_reset), .cbd_readin(cbd_readin),
    .cbd_din_1(cbd_din_1), .cbd_din_2(cbd_din_2), .cbd_ok_in(cbd_ok_in),
    .cbd_readout(cbd_readout), .cbd_ok_out(cbd_ok_out),
    .cbd_dout_1(cbd_dout_1), .cbd_dout_2(cbd_dout_2),
    .poly_ready(poly_ready), .poly_we(poly_we), .poly_addr(poly_addr),
    .poly_wdata(poly_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- cbd model and source ----------------
  logic signed [15:0] mq1[$];
  logic signed [15:0] mq2[$];
  logic [23:0]        expq[$];
  logic               model_has = 1'b0;
  logic               model_room = 1'b1;
  logic signed [15:0] m_d1 = 16'sd0;
  logic signed [15:0] m_d2 = 16'sd0;
  logic               gate_in = 1'b1, gate_out = 1'b1;
  logic               rand_mode = 1'b0, valid_en = 1'b1;
  logic [31:0]        w1 [16];
  logic [31:0]        w2 [16];
  logic [4:0]         widx = 5'd0;
  int                 xfer_cnt = 0;

  assign cbd_ok_out = model_has && gate_out;
  assign cbd_ok_in  = model_room && gate_in;
  assign cbd_dout_1 = m_d1;
  assign cbd_dout_2 = m_d2;
  assign src_data_1 = w1[widx[3:0]];
  assign src_data_2 = w2[widx[3:0]];

  function automatic int nib_coef(input logic [3:0] n);
    return int'(n[0]) + int'(n[1]) - int'(n[2]) - int'(n[3]);
  endfunction

  function automatic logic [11:0] lane(input int c);
    return (c < 0) ? 12'(c + 3329) : 12'(c);
  endfunction

  function automatic logic [3:0] enc(input int c);
    case (c)
      2:       return 4'h3;
      1:       return 4'h1;
      -1:      return 4'h4;
      -2:      return 4'hC;
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit cap, xf, crst;
    logic [63:0] v;
    int c1, c2;
    cap  = cbd_readout && cbd_ok_out;
    xf   = src_valid && src_ready;
    crst = cbd_reset;
    v    = {cbd_din_2, cbd_din_1};
    if (!crst && (xf || (cbd_readin && cbd_ok_in))) begin
      chk("xfer_hs", 32'(cbd_readin && cbd_ok_in), 32'(xf));
      chk("din_1", cbd_din_1, src_data_1);
      chk("din_2", cbd_din_2, src_data_2);
    end
    #1;
    if (crst) begin
      mq1.delete(); mq2.delete(); expq.delete();
      widx = 5'd0;
      xfer_cnt = 0;
    end else begin
      if (cap && mq1.size() > 0) begin
        void'(mq1.pop_front());
        void'(mq2.pop_front());
      end
      if (xf) begin
        for (int i = 0; i < 8; i++) begin
          c1 = nib_coef(v[8*i +: 4]);
          c2 = nib_coef(v[8*i+4 +: 4]);
          mq1.push_back(16'(c1));
          mq2.push_back(16'(c2));
          expq.push_back({lane(c2), lane(c1)});
        end
        widx = widx + 5'd1;
        xfer_cnt++;
      end
    end
    model_has  = (mq1.size() != 0);
    model_room = (mq1.size() <= 8);
    if (mq1.size() != 0) begin
      m_d1 = mq1[0];
      m_d2 = mq2[0];
    end
  end

  always @(negedge clk) begin : gates
    if (rand_mode) begin
      gate_in    = ($urandom_range(0, 1) != 0);
      gate_out   = ($urandom_range(0, 1) != 0);
      src_valid  = valid_en && ($urandom_range(0, 3) != 0);
      poly_ready = ($urandom_range(0, 2) != 0);
    end else begin
      gate_in    = 1'b1;
      gate_out   = 1'b1;
      src_valid  = valid_en;
      poly_ready = 1'b1;
    end
  end

  // ---------------- write monitor / scoreboard ----------------
  int          wr_cnt = 0;
  int          exp_addr = 0;
  int          done_cnt = 0;
  logic [23:0] wr_log [128];

  always @(negedge clk) begin : monitor
    logic [23:0] e;
    if (cbd_reset) begin
      wr_cnt = 0;
      exp_addr = 0;
    end else if (poly_we) begin
      if (expq.size() == 0) begin
        chk("wr_unexpected", 32'(poly_addr), 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        chk("wr_data", 32'(poly_wdata), 32'(e));
      end
      chk("wr_addr", 32'(poly_addr), 32'(exp_addr[6:0]));
      wr_log[poly_addr] = poly_wdata;
      exp_addr++;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      chk("done_we", 32'(poly_we), 32'd1);
      chk("done_addr", 32'(poly_addr), 32'd127);
      chk("done_wrcnt", 32'(wr_cnt), 32'd128);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int          c1;
    int          c2;
    logic [23:0] wd;
  } vec_t;
  vec_t tbl [8];

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_words();
    for (int i = 0; i < 16; i++) begin
      w1[i] = $urandom;
      w2[i] = $urandom;
    end
  endtask

  task automatic wait_done(input int budget, input bit pulse);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      start = (pulse && busy && (n % 37 == 5)) ? 1'b1 : 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic end_checks(input int exp_done);
    chk("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd0);
    chk("writes", 32'(wr_cnt), 32'd128);
    chk("xfers", 32'(xfer_cnt), 32'd16);
    chk("exp_left", 32'(expq.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
  endtask

  initial begin
    logic [63:0] v;
    int n;
    tbl[0] = '{-2,  2, 24'h002CFF};
    tbl[1] = '{-1,  0, 24'h000D00};
    tbl[2] = '{ 1, -1, 24'hD00001};
    tbl[3] = '{ 2, -2, 24'hCFF002};
    tbl[4] = '{ 0,  0, 24'h000000};
    tbl[5] = '{-2, -2, 24'hCFFCFF};
    tbl[6] = '{ 1,  2, 24'h002001};
    tbl[7] = '{-1, -1, 24'hD00D00};
    fill_words();

    // Reset held with start high.
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(poly_we), 32'd0);
    chk("rst_addr", 32'(poly_addr), 32'd0);
    chk("rst_wdata", 32'(poly_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_set", 32'(cbd_set), 32'd0);
    chk("rst_readin", 32'(cbd_readin), 32'd0);
    chk("rst_readout", 32'(cbd_readout), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_cbd_reset", 32'(cbd_reset), 32'd1);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_writes", 32'(wr_cnt), 32'd0);
    chk("idle_cbd_reset", 32'(cbd_reset), 32'd0);

    // Nominal polynomial; first word pair encodes the mapping table.
    for (int i = 0; i < 8; i++) begin
      v[8*i +: 4]   = enc(tbl[i].c1);
      v[8*i+4 +: 4] = enc(tbl[i].c2);
    end
    w1[0] = v[31:0];
    w2[0] = v[63:32];
    do_start();
    chk("clr_cbd_reset", 32'(cbd_reset), 32'd1);
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_set", 32'(cbd_set), 32'd1);
    chk("clr_src_ready", 32'(src_ready), 32'd0);
    @(negedge clk);
    chk("run_cbd_reset", 32'(cbd_reset), 32'd0);
    chk("run_src_ready", 32'(src_ready), 32'd1);
    chk("run_readin", 32'(cbd_readin), 32'd1);
    wait_done(2000, 1'b0);
    end_checks(1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("map%0d", i), 32'(wr_log[i]), 32'(tbl[i].wd));
    end

    // Random backpressure on every handshake.
    fill_words();
    rand_mode = 1'b1;
    do_start();
    wait_done(6000, 1'b0);
    end_checks(2);

    // Abort after 40 writes.
    rand_mode = 1'b0;
    fill_words();
    do_start();
    n = 0;
    while (wr_cnt < 40 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach40", 32'(wr_cnt >= 40), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cbd_reset", 32'(cbd_reset), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_we", 32'(poly_we), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'd2);
    chk("abort_idle", 32'(busy), 32'd0);

    // Restart under backpressure with stray start pulses while busy.
    rand_mode = 1'b1;
    fill_words();
    do_start();
    wait_done(6000, 1'b1);
    end_checks(3);
    repeat (5) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);
    chk("final_done_count", 32'(done_cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
